// File: rtl/mem_port_arbiter_pkg.sv
// Shared LC-3b type package.
// Holds the machine word type plus the types used by the memory port arbiter:
//   lc3b_word       16-bit datapath word
//   lc3b_mem_wmask  2-bit byte-enable mask
//   lc3b_arb_state  arbiter FSM state (IDLE, SERVE_I, SERVE_D)
//   lc3b_mem_port   identifies an initiator port (PORT_I = fetch, PORT_D = data)
//   rr_pick         round-robin winner selection between the two ports
package lc3b_types;

  typedef logic [15:0] lc3b_word;
  typedef logic [1:0]  lc3b_mem_wmask;

  typedef enum logic [1:0] {
    IDLE,
    SERVE_I,
    SERVE_D
  } lc3b_arb_state;

  typedef enum logic {
    PORT_I,
    PORT_D
  } lc3b_mem_port;

  // Winner for the current request pair. A lone request always wins; on a
  // tie the port that did not win last time goes next. With no request the
  // result is unused.
  function automatic lc3b_mem_port rr_pick(input logic req_i,
                                           input logic req_d,
                                           input lc3b_mem_port last);
    if (req_i && req_d) begin
      return (last == PORT_I) ? PORT_D : PORT_I;
    end
    return req_d ? PORT_D : PORT_I;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_sat_counter.sv
// Saturating up-counter used for the arbiter performance counters.
// Ports:
//   clk    clock, rising edge
//   rst    asynchronous active-high reset, count -> 0
//   clr    synchronous clear; dominates inc
//   inc    increment request for this cycle
//   count  current count, sticks at all-ones
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Memory port arbiter: serialises the pipeline's instruction-fetch (IF) and
// data (MEM) memory ports onto one downstream pmem port using the same
// read/write/resp handshake, with round-robin arbitration on ties.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   if_*                     IF initiator: read-only request, resp + rdata back
//   mem_*                    MEM initiator: read/write request, resp + rdata back
//   pmem_*                   downstream port; request side is registered,
//                            pmem_resp/pmem_rdata are forwarded combinationally
//   count_clear              synchronous clear of all performance counters
//   i_grant_count            IF grants issued (saturating)
//   d_grant_count            MEM grants issued (saturating)
//   conflict_count           cycles a request was kept waiting (saturating)
module mem_port_arbiter
  import lc3b_types::*;
#(
  parameter int   CNT_W   = 16,
  parameter logic D_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,

  input  logic [15:0]      if_memaddr,
  input  logic             if_memread,
  input  logic [1:0]       if_mem_byte_enable,
  output logic             if_mem_resp,
  output logic [15:0]      if_mem_rdata,

  input  logic [15:0]      mem_memaddr,
  input  logic             mem_memread,
  input  logic             mem_memwrite,
  input  logic [15:0]      mem_mem_wdata,
  input  logic [1:0]       mem_mem_byte_enable,
  output logic             mem_mem_resp,
  output logic [15:0]      mem_mem_rdata,

  output logic [15:0]      pmem_address,
  output logic             pmem_read,
  output logic             pmem_write,
  output logic [15:0]      pmem_wdata,
  output logic [1:0]       pmem_byte_enable,
  input  logic             pmem_resp,
  input  logic [15:0]      pmem_rdata,

  input  logic             count_clear,
  output logic [CNT_W-1:0] i_grant_count,
  output logic [CNT_W-1:0] d_grant_count,
  output logic [CNT_W-1:0] conflict_count
);

  lc3b_arb_state state, next_state;
  lc3b_mem_port  last_grant;
  lc3b_mem_port  winner;

  logic req_i, req_d;
  logic grant;
  logic done;
  logic inc_i, inc_d, inc_conflict;

  always_comb begin
    req_i        = if_memread;
    req_d        = mem_memread | mem_memwrite;
    winner       = rr_pick(req_i, req_d, last_grant);
    grant        = 1'b0;
    done         = 1'b0;
    inc_i        = 1'b0;
    inc_d        = 1'b0;
    inc_conflict = 1'b0;
    next_state   = state;
    if_mem_resp   = 1'b0;
    if_mem_rdata  = '0;
    mem_mem_resp  = 1'b0;
    mem_mem_rdata = '0;

    unique case (state)
      IDLE: begin
        // pmem_resp is deliberately ignored here: no transaction is owned.
        if (req_i || req_d) begin
          grant        = 1'b1;
          inc_i        = (winner == PORT_I);
          inc_d        = (winner == PORT_D);
          inc_conflict = req_i && req_d;
          next_state   = (winner == PORT_D) ? SERVE_D : SERVE_I;
        end
      end
      SERVE_I: begin
        inc_conflict = req_d;
        if (pmem_resp) begin
          done         = 1'b1;
          if_mem_resp  = 1'b1;
          if_mem_rdata = pmem_rdata;
          next_state   = IDLE;
        end
      end
      SERVE_D: begin
        inc_conflict = req_i;
        if (pmem_resp) begin
          done          = 1'b1;
          mem_mem_resp  = 1'b1;
          mem_mem_rdata = pmem_rdata;
          next_state    = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      // Seeding last_grant with the opposite port makes D_FIRST's port win
      // the first tie.
      last_grant <= D_FIRST ? PORT_I : PORT_D;
    end else begin
      state <= next_state;
      if (grant) begin
        last_grant <= winner;
      end
    end
  end

  // Downstream request registers: loaded on grant, held through the serve
  // phase, request strobes dropped on the completing edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pmem_address     <= '0;
      pmem_read        <= 1'b0;
      pmem_write       <= 1'b0;
      pmem_wdata       <= '0;
      pmem_byte_enable <= '0;
    end else if (grant) begin
      if (winner == PORT_D) begin
        pmem_address     <= mem_memaddr;
        pmem_byte_enable <= mem_mem_byte_enable;
        pmem_wdata       <= mem_mem_wdata;
        // A simultaneous read+write request is treated as a write.
        pmem_write       <= mem_memwrite;
        pmem_read        <= ~mem_memwrite;
      end else begin
        pmem_address     <= if_memaddr;
        pmem_byte_enable <= if_mem_byte_enable;
        pmem_read        <= 1'b1;
        pmem_write       <= 1'b0;
      end
    end else if (done) begin
      pmem_read  <= 1'b0;
      pmem_write <= 1'b0;
    end
  end

  sat_counter #(.W(CNT_W)) u_i_grant_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (count_clear),
    .inc   (inc_i),
    .count (i_grant_count)
  );

  sat_counter #(.W(CNT_W)) u_d_grant_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (count_clear),
    .inc   (inc_d),
    .count (d_grant_count)
  );

  sat_counter #(.W(CNT_W)) u_conflict_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (count_clear),
    .inc   (inc_conflict),
    .count (conflict_count)
  );

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int   CW = 4;
  localparam logic DF = 1'b1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [15:0]   if_memaddr = '0;
  logic          if_memread = 1'b0;
  logic [1:0]    if_mem_byte_enable = '0;
  logic          if_mem_resp;
  logic [15:0]   if_mem_rdata;
  logic [15:0]   mem_memaddr = '0;
  logic          mem_memread = 1'b0;
  logic          mem_memwrite = 1'b0;
  logic [15:0]   mem_mem_wdata = '0;
  logic [1:0]    mem_mem_byte_enable = '0;
  logic          mem_mem_resp;
  logic [15:0]   mem_mem_rdata;
  logic [15:0]   pmem_address;
  logic          pmem_read;
  logic          pmem_write;
  logic [15:0]   pmem_wdata;
  logic [1:0]    pmem_byte_enable;
  logic          pmem_resp = 1'b0;
  logic [15:0]   pmem_rdata = '0;
  logic          count_clear = 1'b0;
  logic [CW-1:0] i_grant_count;
  logic [CW-1:0] d_grant_count;
  logic [CW-1:0] conflict_count;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.CNT_W(CW), .D_FIRST(DF)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .if_memaddr          (if_memaddr),
    .if_memread          (if_memread),
    .if_mem_byte_enable  (if_mem_byte_enable),
    .if_mem_resp         (if_mem_resp),
    .if_mem_rdata        (if_mem_rdata),
    .mem_memaddr         (mem_memaddr),
    .mem_memread         (mem_memread),
    .mem_memwrite        (mem_memwrite),
    .mem_mem_wdata       (mem_mem_wdata),
    .mem_mem_byte_enable (mem_mem_byte_enable),
    .mem_mem_resp        (mem_mem_resp),
    .mem_mem_rdata       (mem_mem_rdata),
    .pmem_address        (pmem_address),
    .pmem_read           (pmem_read),
    .pmem_write          (pmem_write),
    .pmem_wdata          (pmem_wdata),
    .pmem_byte_enable    (pmem_byte_enable),
    .pmem_resp           (pmem_resp),
    .pmem_rdata          (pmem_rdata),
    .count_clear         (count_clear),
    .i_grant_count       (i_grant_count),
    .d_grant_count       (d_grant_count),
    .conflict_count      (conflict_count)
  );

  always #5 clk = ~clk;

  // Transaction-level reference: is the downstream port busy, who owns it,
  // what was captured, and how many grants/conflicts were seen.
  logic          m_busy, m_owner_d, m_last_d, m_rd, m_wr;
  logic [15:0]   m_addr, m_wdata;
  logic [1:0]    m_be;
  logic [CW-1:0] m_ci, m_cd, m_cc;

  logic want_i, want_d, pick_d, waiting;
  assign want_i  = if_memread;
  assign want_d  = mem_memread | mem_memwrite;
  assign pick_d  = want_d && (!want_i || !m_last_d);
  assign waiting = m_busy ? (m_owner_d ? want_i : want_d) : (want_i && want_d);

  function automatic logic [CW-1:0] bump(input logic [CW-1:0] v, input logic clr,
                                         input logic inc);
    if (clr) return '0;
    if (inc && v != {CW{1'b1}}) return v + 1'b1;
    return v;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 1'b0; m_owner_d <= 1'b0; m_last_d <= !DF;
      m_rd <= 1'b0; m_wr <= 1'b0; m_addr <= '0; m_wdata <= '0; m_be <= '0;
      m_ci <= '0; m_cd <= '0; m_cc <= '0;
    end else begin
      m_cc <= bump(m_cc, count_clear, waiting);
      m_ci <= bump(m_ci, count_clear, !m_busy && want_i && !pick_d);
      m_cd <= bump(m_cd, count_clear, !m_busy && pick_d);
      if (!m_busy) begin
        if (want_i || want_d) begin
          m_busy    <= 1'b1;
          m_owner_d <= pick_d;
          m_last_d  <= pick_d;
          m_addr    <= pick_d ? mem_memaddr : if_memaddr;
          m_be      <= pick_d ? mem_mem_byte_enable : if_mem_byte_enable;
          m_wdata   <= mem_mem_wdata;
          m_wr      <= pick_d && mem_memwrite;
          m_rd      <= !(pick_d && mem_memwrite);
        end
      end else if (pmem_resp) begin
        m_busy <= 1'b0;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    if_memread = 1'b0; mem_memread = 1'b0; mem_memwrite = 1'b0;
    pmem_resp = 1'b0; count_clear = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    checks++;
    if ({pmem_read, pmem_write, if_mem_resp, mem_mem_resp} !== 4'b0000) begin
      errors++; $display("FAIL reset_strobes got %b exp 0000",
                         {pmem_read, pmem_write, if_mem_resp, mem_mem_resp});
    end
    checks++;
    if ({pmem_address, pmem_wdata, pmem_byte_enable} !== 34'h0) begin
      errors++; $display("FAIL reset_regs got %h exp 0",
                         {pmem_address, pmem_wdata, pmem_byte_enable});
    end
    checks++;
    if ({i_grant_count, d_grant_count, conflict_count} !== '0) begin
      errors++; $display("FAIL reset_counts got %h exp 0",
                         {i_grant_count, d_grant_count, conflict_count});
    end
    do_reset();
  endtask

  task automatic test_if_read();
    do_reset();
    if_memaddr = 16'h0040; if_mem_byte_enable = 2'b11; if_memread = 1'b1;
    cyc();
    checks++;
    if (pmem_read !== 1'b1 || pmem_write !== 1'b0 || pmem_address !== 16'h0040) begin
      errors++; $display("FAIL if_grant got r%b w%b a%h exp r1 w0 a0040",
                         pmem_read, pmem_write, pmem_address);
    end
    for (int unsigned k = 0; k < 3; k++) begin
      pmem_resp  = (k == 2);
      pmem_rdata = (k == 2) ? 16'h1234 : 16'hDEAD;
      #1;
      checks++;
      if (if_mem_resp !== (k == 2) || mem_mem_resp !== 1'b0) begin
        errors++; $display("FAIL if_resp_k%0d got %b/%b exp %b/0", k,
                           if_mem_resp, mem_mem_resp, (k == 2));
      end
      if (k == 2) begin
        checks++;
        if (if_mem_rdata !== 16'h1234) begin
          errors++; $display("FAIL if_rdata got %h exp 1234", if_mem_rdata);
        end
      end
      cyc();
    end
    if_memread = 1'b0; pmem_resp = 1'b0;
    #1;
    checks++;
    if (pmem_read !== 1'b0 || if_mem_resp !== 1'b0 || i_grant_count !== 4'd1) begin
      errors++; $display("FAIL if_done got r%b resp%b cnt%0d exp r0 resp0 cnt1",
                         pmem_read, if_mem_resp, i_grant_count);
    end
  endtask

  task automatic test_tie_dfirst();
    do_reset();
    if_memaddr = 16'h0080; if_mem_byte_enable = 2'b11; if_memread = 1'b1;
    mem_memaddr = 16'h0100; mem_mem_wdata = 16'hBEEF; mem_mem_byte_enable = 2'b01;
    mem_memwrite = 1'b1;
    cyc();
    checks++;
    if (pmem_write !== 1'b1 || pmem_read !== 1'b0 || pmem_wdata !== 16'hBEEF ||
        pmem_address !== 16'h0100 || pmem_byte_enable !== 2'b01) begin
      errors++; $display("FAIL tie_d_first got w%b r%b d%h a%h be%b exp w1 r0 dBEEF a0100 be01",
                         pmem_write, pmem_read, pmem_wdata, pmem_address, pmem_byte_enable);
    end
    for (int unsigned k = 0; k < 2; k++) begin
      pmem_resp = (k == 1); pmem_rdata = 16'h5A5A;
      #1;
      checks++;
      if (mem_mem_resp !== (k == 1) || if_mem_resp !== 1'b0) begin
        errors++; $display("FAIL tie_mem_resp_k%0d got %b/%b exp %b/0", k,
                           mem_mem_resp, if_mem_resp, (k == 1));
      end
      cyc();
    end
    mem_memwrite = 1'b0; pmem_resp = 1'b0;
    cyc();
    checks++;
    if (pmem_read !== 1'b1 || pmem_write !== 1'b0 || pmem_address !== 16'h0080) begin
      errors++; $display("FAIL tie_if_next got r%b w%b a%h exp r1 w0 a0080",
                         pmem_read, pmem_write, pmem_address);
    end
    checks++;
    if (conflict_count !== 4'd3) begin
      errors++; $display("FAIL tie_conflicts got %0d exp 3", conflict_count);
    end
    pmem_resp = 1'b1;
    #1;
    checks++;
    if (if_mem_resp !== 1'b1 || mem_mem_resp !== 1'b0) begin
      errors++; $display("FAIL tie_if_resp got %b/%b exp 1/0", if_mem_resp, mem_mem_resp);
    end
    cyc();
    if_memread = 1'b0; pmem_resp = 1'b0;
    #1;
    checks++;
    if (i_grant_count !== 4'd1 || d_grant_count !== 4'd1) begin
      errors++; $display("FAIL tie_grants got i%0d d%0d exp i1 d1", i_grant_count, d_grant_count);
    end
  endtask

  task automatic test_back_to_back();
    int unsigned lat;
    do_reset();
    if_memread = 1'b1; mem_memwrite = 1'b1;
    for (int unsigned t = 0; t < 6; t++) begin
      if_memaddr = 16'h1000 + 16'(t); mem_memaddr = 16'h2000 + 16'(t);
      // downstream completion while idle must not reach either initiator
      pmem_resp = 1'b1; pmem_rdata = 16'($urandom);
      #1;
      checks++;
      if (if_mem_resp !== 1'b0 || mem_mem_resp !== 1'b0) begin
        errors++; $display("FAIL b2b_idle_resp t%0d got %b/%b exp 0/0", t,
                           if_mem_resp, mem_mem_resp);
      end
      cyc();
      pmem_resp = 1'b0;
      checks++;
      if (pmem_write !== (t % 2 == 0) || pmem_read !== (t % 2 == 1)) begin
        errors++; $display("FAIL b2b_order t%0d got w%b r%b exp w%b r%b", t,
                           pmem_write, pmem_read, (t % 2 == 0), (t % 2 == 1));
      end
      lat = $urandom_range(1, 3);
      for (int unsigned c = 0; c < lat; c++) begin
        pmem_resp = (c == lat - 1);
        #1;
        checks++;
        if (mem_mem_resp !== (c == lat - 1 && t % 2 == 0) ||
            if_mem_resp !== (c == lat - 1 && t % 2 == 1)) begin
          errors++; $display("FAIL b2b_resp t%0d c%0d got i%b d%b", t, c,
                             if_mem_resp, mem_mem_resp);
        end
        cyc();
      end
      pmem_resp = 1'b0;
    end
    if_memread = 1'b0; mem_memwrite = 1'b0;
    #1;
    checks++;
    if (i_grant_count !== m_ci || d_grant_count !== m_cd || conflict_count !== m_cc) begin
      errors++; $display("FAIL b2b_counts got %0d/%0d/%0d exp %0d/%0d/%0d",
                         i_grant_count, d_grant_count, conflict_count, m_ci, m_cd, m_cc);
    end
  endtask

  task automatic test_rw_both();
    do_reset();
    mem_memaddr = 16'h0200; mem_mem_byte_enable = 2'b11;
    mem_memread = 1'b1; mem_memwrite = 1'b1;
    cyc();
    checks++;
    if (pmem_write !== 1'b1 || pmem_read !== 1'b0 || pmem_address !== 16'h0200) begin
      errors++; $display("FAIL rw_write_wins got w%b r%b a%h exp w1 r0 a0200",
                         pmem_write, pmem_read, pmem_address);
    end
    pmem_resp = 1'b1; pmem_rdata = 16'h7777;
    #1;
    checks++;
    if (mem_mem_resp !== 1'b1 || mem_mem_rdata !== 16'h7777) begin
      errors++; $display("FAIL rw_resp got %b %h exp 1 7777", mem_mem_resp, mem_mem_rdata);
    end
    cyc();
    mem_memread = 1'b0; mem_memwrite = 1'b0; pmem_resp = 1'b0;
    cyc();
    checks++;
    if (mem_mem_resp !== 1'b0 || pmem_write !== 1'b0 || d_grant_count !== 4'd1) begin
      errors++; $display("FAIL rw_single got resp%b w%b cnt%0d exp 0 0 1",
                         mem_mem_resp, pmem_write, d_grant_count);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    mem_memaddr = 16'h0300; mem_mem_wdata = 16'hCAFE; mem_memwrite = 1'b1;
    cyc();
    cyc();
    checks++;
    if (pmem_write !== 1'b1) begin
      errors++; $display("FAIL mid_pre got w%b exp 1", pmem_write);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (pmem_write !== 1'b0 || pmem_address !== 16'h0000 || d_grant_count !== '0) begin
      errors++; $display("FAIL mid_async_drop got w%b a%h d%0d exp 0 0000 0",
                         pmem_write, pmem_address, d_grant_count);
    end
    mem_memwrite = 1'b0;
    #2;
    rst = 1'b0;
    cyc();
    if_memaddr = 16'h0400; if_memread = 1'b1;
    cyc();
    checks++;
    if (pmem_read !== 1'b1 || pmem_write !== 1'b0 || pmem_address !== 16'h0400) begin
      errors++; $display("FAIL mid_regrant got r%b w%b a%h exp 1 0 0400",
                         pmem_read, pmem_write, pmem_address);
    end
    pmem_resp = 1'b1;
    cyc();
    if_memread = 1'b0; pmem_resp = 1'b0;
    #1;
    checks++;
    if (i_grant_count !== 4'd1 || d_grant_count !== 4'd0) begin
      errors++; $display("FAIL mid_counts got i%0d d%0d exp 1 0", i_grant_count, d_grant_count);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    if_memaddr = 16'h0010; if_memread = 1'b1;
    for (int unsigned n = 1; n <= 17; n++) begin
      cyc();
      checks++;
      if (i_grant_count !== ((n > 15) ? 4'hF : 4'(n))) begin
        errors++; $display("FAIL sat_count n%0d got %0d exp %0d", n, i_grant_count,
                           (n > 15) ? 15 : n);
      end
      pmem_resp = 1'b1;
      cyc();
      pmem_resp = 1'b0;
    end
    mem_memread = 1'b1;
    cyc();
    pmem_resp = 1'b1;
    cyc();
    pmem_resp = 1'b0;
    mem_memread = 1'b0;
    // IDLE with IF requesting: grant and clear land on the same edge
    count_clear = 1'b1;
    cyc();
    count_clear = 1'b0;
    checks++;
    if (i_grant_count !== '0 || d_grant_count !== '0 || conflict_count !== '0) begin
      errors++; $display("FAIL clear_wins got %0d/%0d/%0d exp 0/0/0",
                         i_grant_count, d_grant_count, conflict_count);
    end
    checks++;
    if (pmem_read !== 1'b1) begin
      errors++; $display("FAIL clear_grant got r%b exp 1", pmem_read);
    end
    pmem_resp = 1'b1;
    cyc();
    pmem_resp = 1'b0; if_memread = 1'b0;
  endtask

  task automatic test_random();
    logic i_pend, d_pend, got_i, got_d, ex_i, ex_d;
    i_pend = 1'b0; d_pend = 1'b0; got_i = 1'b0; got_d = 1'b0;
    do_reset();
    for (int unsigned cyc_n = 0; cyc_n < 600; cyc_n++) begin
      checks++;
      if (pmem_read !== (m_busy && m_rd) || pmem_write !== (m_busy && m_wr)) begin
        errors++; $display("FAIL rnd_strobe c%0d got r%b w%b exp r%b w%b", cyc_n,
                           pmem_read, pmem_write, m_busy && m_rd, m_busy && m_wr);
      end
      if (m_busy) begin
        checks++;
        if (pmem_address !== m_addr || pmem_byte_enable !== m_be ||
            (m_wr && pmem_wdata !== m_wdata)) begin
          errors++; $display("FAIL rnd_capture c%0d got a%h be%b d%h exp a%h be%b d%h", cyc_n,
                             pmem_address, pmem_byte_enable, pmem_wdata, m_addr, m_be, m_wdata);
        end
      end
      checks++;
      if (i_grant_count !== m_ci || d_grant_count !== m_cd || conflict_count !== m_cc) begin
        errors++; $display("FAIL rnd_counts c%0d got %0d/%0d/%0d exp %0d/%0d/%0d", cyc_n,
                           i_grant_count, d_grant_count, conflict_count, m_ci, m_cd, m_cc);
      end
      if (got_i) i_pend = 1'b0;
      if (got_d) d_pend = 1'b0;
      if (!i_pend && ($urandom_range(0, 2) == 0)) begin
        i_pend = 1'b1;
        if_memaddr = 16'($urandom); if_mem_byte_enable = 2'($urandom);
      end
      if (!d_pend && ($urandom_range(0, 2) == 0)) begin
        d_pend = 1'b1;
        mem_memaddr = 16'($urandom); mem_mem_wdata = 16'($urandom);
        mem_mem_byte_enable = 2'($urandom);
        case ($urandom_range(0, 2))
          0:       begin mem_memread = 1'b1; mem_memwrite = 1'b0; end
          1:       begin mem_memread = 1'b0; mem_memwrite = 1'b1; end
          default: begin mem_memread = 1'b1; mem_memwrite = 1'b1; end
        endcase
      end
      if_memread = i_pend;
      if (!d_pend) begin mem_memread = 1'b0; mem_memwrite = 1'b0; end
      count_clear = ($urandom_range(0, 31) == 0);
      pmem_resp   = m_busy ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 4) == 0);
      pmem_rdata  = 16'($urandom);
      #1;
      ex_i = m_busy && !m_owner_d && pmem_resp;
      ex_d = m_busy && m_owner_d && pmem_resp;
      checks++;
      if (if_mem_resp !== ex_i || mem_mem_resp !== ex_d ||
          if_mem_rdata !== (ex_i ? pmem_rdata : 16'h0) ||
          mem_mem_rdata !== (ex_d ? pmem_rdata : 16'h0)) begin
        errors++; $display("FAIL rnd_resp c%0d got i%b:%h d%b:%h exp i%b d%b data %h", cyc_n,
                           if_mem_resp, if_mem_rdata, mem_mem_resp, mem_mem_rdata,
                           ex_i, ex_d, pmem_rdata);
      end
      got_i = ex_i; got_d = ex_d;
      cyc();
    end
    if_memread = 1'b0; mem_memread = 1'b0; mem_memwrite = 1'b0;
    pmem_resp = 1'b0; count_clear = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_if_read();
    test_tie_dfirst();
    test_back_to_back();
    test_rw_both();
    test_reset_mid();
    test_saturation();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Responder for the pipeline's two memory initiator ports: instruction fetch (IF) and data (MEM).
- Serialises requests from both ports onto one downstream memory port (pmem_*) that uses the same read/write/resp handshake.
- Sits between the pipeline datapath and the unified lower memory (cache or physical memory).
- Keeps saturating performance counters that the EXE-stage counter readout can consume.

Parameters:
- CNT_W, 16, width of each performance counter.
- D_FIRST, 1, winner on the first-ever simultaneous request after reset (1 = MEM port, 0 = IF port).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset; asynchronous, active-high.
- if_memaddr  input  16  IF request address.
- if_memread  input  1  IF read request; held until if_mem_resp.
- if_mem_byte_enable  input  2  IF byte enables.
- if_mem_resp  output  1  one-cycle completion pulse to IF.
- if_mem_rdata  output  16  IF read data; valid only when if_mem_resp=1.
- mem_memaddr  input  16  MEM request address.
- mem_memread  input  1  MEM read request.
- mem_memwrite  input  1  MEM write request.
- mem_mem_wdata  input  16  MEM write data.
- mem_mem_byte_enable  input  2  MEM byte enables.
- mem_mem_resp  output  1  one-cycle completion pulse to MEM.
- mem_mem_rdata  output  16  MEM read data; valid only when mem_mem_resp=1.
- pmem_address  output  16  downstream address (registered).
- pmem_read  output  1  downstream read (registered).
- pmem_write  output  1  downstream write (registered).
- pmem_wdata  output  16  downstream write data (registered).
- pmem_byte_enable  output  2  downstream byte enables (registered).
- pmem_resp  input  1  downstream completion.
- pmem_rdata  input  16  downstream read data.
- count_clear  input  1  synchronous clear of all counters.
- i_grant_count  output  CNT_W  IF grants issued.
- d_grant_count  output  CNT_W  MEM grants issued.
- conflict_count  output  CNT_W  cycles a request waits while the other port owns pmem or wins arbitration.

Behaviour:
- Reset values:
  - State IDLE; pmem_read, pmem_write = 0; pmem_address, pmem_wdata = 0; pmem_byte_enable = 0.
  - Both resp outputs 0; all counters 0.
  - last_grant = IF if D_FIRST=1, MEM if D_FIRST=0, so MEM wins the first tie when D_FIRST=1.
- FSM states: IDLE, SERVE_I, SERVE_D.
- IDLE:
  - Sample requests: req_i = if_memread; req_d = mem_memread | mem_memwrite.
  - Only one request: grant it.
  - Both requests: grant the port not in last_grant (round-robin).
  - On grant, in the same edge:
    - Capture address, byte enable and wdata into the pmem registers.
    - Set pmem_read/pmem_write.
    - Update last_grant, increment the grant counter, move to SERVE_I or SERVE_D.
  - Grant latency: pmem request is visible in the cycle after the request is first seen in IDLE.
- MEM port with mem_memread and mem_memwrite both high: write wins; pmem_read=0, pmem_write=1.
- IF port never writes; pmem_write=0 on IF grants.
- SERVE_x:
  - pmem outputs are held stable; initiator inputs are ignored (captured copy is used).
  - When pmem_resp=1, pass it combinationally:
    - x_resp = 1 in the same cycle.
    - x_rdata = pmem_rdata, forwarded for reads and writes alike.
  - Non-owner resp is 0; non-owner rdata is 0.
  - On that edge: clear pmem_read/pmem_write and return to IDLE.
  - Result: no back-to-back re-serve of a stale request; initiators update their request on the resp edge.
- Minimum occupancy: 1 IDLE cycle + N SERVE cycles per transaction. IDLE never asserts any resp.
- pmem_resp while in IDLE is ignored (no resp output).
- Counters:
  - Saturate at all-ones; no wrap.
  - count_clear wins over a simultaneous increment; counters read 0 next cycle.
  - conflict_count increments once per cycle where:
    - state is SERVE_I and req_d=1, or
    - state is SERVE_D and req_i=1, or
    - state is IDLE and both requests are high (the loser's cycle).
- Reset mid-transaction: immediate return to reset values.
  - Downstream read/write drop asynchronously.
  - The in-flight request is abandoned, not replayed; the initiator re-requests after reset.

Decomposition:
- Shared package lc3b_types:
  - Add typedef lc3b_arb_state (IDLE, SERVE_I, SERVE_D).
  - Add typedef lc3b_mem_port (PORT_I, PORT_D).
  - Reuse the existing lc3b_word type.
- One sub-module: sat_counter (parameter W; inputs clk, rst, clr, inc; output count), instantiated three times.
- FSM and capture registers stay in mem_port_arbiter.

Test Plan:
1. IF read alone, addr 16'h0040, pmem_resp after 3 cycles with rdata 16'h1234 -> pmem_read=1, pmem_address=16'h0040 one cycle after request; if_mem_resp pulses 1 cycle with 16'h1234; i_grant_count=1.
2. IF read and MEM write (addr 16'h0100, wdata 16'hBEEF, be 2'b01) asserted together after reset, D_FIRST=1 -> MEM served first (pmem_write=1, wdata 16'hBEEF); IF served next; conflict_count = 1 + MEM SERVE cycles.
3. Both ports request continuously for 6 transactions -> grants alternate D,I,D,I,D,I; no resp pulses overlap; each resp is exactly 1 cycle.
4. MEM asserts memread and memwrite together, addr 16'h0200 -> pmem_write=1, pmem_read=0; mem_mem_resp pulses once.
5. rst asserted mid-SERVE_D, pmem_resp never returned -> pmem_write drops to 0 without a clock edge; after release state is IDLE and a fresh IF read is granted normally.
6. Preload i_grant_count to 16'hFFFE via 3 more IF grants -> holds 16'hFFFF. Then count_clear together with a grant -> all counters 0 next cycle.
